nv_nvdla_sdp_x1_op_sched: RTL and testbench
===========================================

NV_NVDLA_SDP_X1_OP_SCHED -- requirements
Module: nv_nvdla_sdp_x1_op_sched

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 nvdla_core_clk  in  1  core clock; all state on rising edge.
REQ-003 nvdla_core_rst  in  1  asynchronous active-high reset.
REQ-004 op_en  in  1  start pulse; latches cfg_*; ignored unless IDLE.
REQ-005 cfg_width, cfg_height, cfg_channel  in  13 each  cube width, height, channel-group count; all minus-one encoded.
REQ-006 cfg_alu_src, cfg_alu_bypass, cfg_mul_src, cfg_mul_bypass  in  1 each; a channel is active iff src=1 and bypass=0.
REQ-007 op_in_pvld / op_in_prdy  in / out  1  operand stream handshake; op_in_pd  in  32  {mul_op[15:0], alu_op[15:0]}.
REQ-008 chn_alu_op_pvld / chn_alu_op_prdy  out / in  1; chn_alu_op  out  16  held per-channel ALU operand.
REQ-009 chn_mul_op_pvld / chn_mul_op_prdy  out / in  1; chn_mul_op  out  16  held per-channel MUL operand.
REQ-010 busy  out  1  high outside IDLE; done  out  1  one-cycle pulse at completion.
REQ-011 perf_stall_cnt  out  32  stall counter (see Configuration).

Function
REQ-012 FSM states IDLE, RUN, DONE; IDLE->RUN on op_en; RUN->DONE once all groups are fetched and all active slots are empty; DONE->IDLE unconditionally after one cycle, done=1 only in DONE.
REQ-013 op_en with no active channel SHALL go IDLE->RUN->DONE->IDLE with zero op_in beats.
REQ-014 Each channel has one slot: operand register, full flag, w counter, h counter.
REQ-015 op_in_prdy = RUN & (group_cnt <= cfg_channel) & every active slot empty; registered state only, no combinational path from chn_*_prdy.
REQ-016 On op_in accept: each active slot loads its half of op_in_pd, sets full, clears w/h counters; group_cnt increments; inactive halves are discarded.
REQ-017 chn_x_op_pvld = slot full; chn_x_op = slot register; the register is stable while full.
REQ-018 Each slot handshake increments w; at w==cfg_width, w wraps to 0 and h increments; a handshake at w==cfg_width and h==cfg_height clears full.
REQ-019 Each operand is therefore presented for exactly (cfg_width+1)*(cfg_height+1) handshakes; no multiplier is used.
REQ-020 Slots drain independently; the next fetch waits for the slower active slot, giving a minimum one-cycle bubble per group.
REQ-021 Inactive-channel outputs: pvld=0, data=0.
REQ-022 op_en during RUN/DONE is ignored; latched cfg is unaffected.

Reset
REQ-023 On reset assertion: FSM=IDLE, all slots empty, all counters and registers 0, and every output 0 (including op_in_prdy, done, busy, perf_stall_cnt), regardless of clock.
REQ-024 Reset mid-RUN discards held operands; the first cycle after deassertion behaves as IDLE.

Configuration
REQ-025 Macro NVDLA_SDP_X1_OP_SCHED_PERF_EN: when defined, perf_stall_cnt counts RUN cycles in which any active slot is empty; the counter saturates at 0xFFFFFFFF and clears on op_en.
REQ-026 When the macro is undefined, perf_stall_cnt SHALL be tied to 0, and no counter logic is present.

Structure
REQ-027 Shared package nv_nvdla_sdp_x1_op_sched_pkg holds the FSM state enum, OP_DW=16, DIM_W=13, and PD_W=32.
REQ-028 Sub-module nv_nvdla_sdp_x1_op_slot (register, full flag, w/h counters) SHALL be instantiated once for ALU and once for MUL.

Verification
REQ-029 Both active, W=1, H=0, C=1; ops 0x0002_0001, 0x0004_0003; prdy=1 -> ALU 1,1,3,3; MUL 2,2,4,4; done one cycle after last beat.
REQ-030 ALU-only (mul_bypass=1), W=H=C=0, op 0xBEEF_1234 -> chn_alu_op=0x1234 for one beat; mul pvld stays 0; exactly 1 op_in beat.
REQ-031 Both active, chn_mul_op_prdy held 0 for 10 cycles -> ALU slot drains, op_in_prdy stays 0 until the MUL slot drains; with PERF_EN, stall count >= 10.
REQ-032 No active channel, op_en -> busy high 2 cycles, done pulse, op_in_prdy never 1.
REQ-033 Reset asserted mid-RUN while slots are full -> outputs 0 asynchronously; after release, a new op_en starts from group 0.
REQ-034 W=8191, H=0, C=0 -> operand held exactly 8192 handshakes; the w counter wraps with no overflow.

Source files
------------

// File: rtl/nv_nvdla_sdp_x1_op_sched_pkg.sv
// Shared types and sizes for the SDP X1 operand scheduler.
package nv_nvdla_sdp_x1_op_sched_pkg;

  localparam int OP_DW = 16;
  localparam int DIM_W = 13;
  localparam int PD_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // A channel consumes operands only when sourced from the stream and not bypassed.
  function automatic logic chn_active(input logic src, input logic bypass);
    return src & ~bypass;
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_x1_op_sched_if.sv
// Operand stream in, per-channel ALU/MUL operand streams out.
interface nv_nvdla_sdp_x1_op_sched_if;
  import nv_nvdla_sdp_x1_op_sched_pkg::*;

  logic              op_in_pvld;
  logic              op_in_prdy;
  logic [PD_W-1:0]   op_in_pd;
  logic              chn_alu_op_pvld;
  logic              chn_alu_op_prdy;
  logic [OP_DW-1:0]  chn_alu_op;
  logic              chn_mul_op_pvld;
  logic              chn_mul_op_prdy;
  logic [OP_DW-1:0]  chn_mul_op;

  modport slave (
    input  op_in_pvld, op_in_pd, chn_alu_op_prdy, chn_mul_op_prdy,
    output op_in_prdy, chn_alu_op_pvld, chn_alu_op, chn_mul_op_pvld, chn_mul_op
  );

  modport master (
    output op_in_pvld, op_in_pd, chn_alu_op_prdy, chn_mul_op_prdy,
    input  op_in_prdy, chn_alu_op_pvld, chn_alu_op, chn_mul_op_pvld, chn_mul_op
  );

endinterface

// File: rtl/nv_nvdla_sdp_x1_op_slot.sv
// One operand slot: holds an operand and replays it for (width+1)*(height+1)
// handshakes using nested w/h counters.
module nv_nvdla_sdp_x1_op_slot
  import nv_nvdla_sdp_x1_op_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OP_DW-1:0] load_data,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             op_prdy,
  output logic             full,
  output logic [OP_DW-1:0] op
);

  logic [DIM_W-1:0] w_cnt;
  logic [DIM_W-1:0] h_cnt;
  logic             hs;
  logic             last_w;
  logic             last_h;

  assign hs     = full & op_prdy;
  assign last_w = (w_cnt == cfg_width);
  assign last_h = (h_cnt == cfg_height);

  // Counters compare against the limit before incrementing, so w never overflows at 8191.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      op    <= '0;
      w_cnt <= '0;
      h_cnt <= '0;
    end else if (load) begin
      full  <= 1'b1;
      op    <= load_data;
      w_cnt <= '0;
      h_cnt <= '0;
    end else if (hs) begin
      if (last_w) begin
        w_cnt <= '0;
        if (last_h) begin
          full  <= 1'b0;
          h_cnt <= '0;
        end else begin
          h_cnt <= h_cnt + DIM_W'(1);
        end
      end else begin
        w_cnt <= w_cnt + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_x1_op_sched.sv
// SDP X1 operand scheduler: fetches one operand group per beat and replays it
// per channel. Optional stall counter under NVDLA_SDP_X1_OP_SCHED_PERF_EN.
module nv_nvdla_sdp_x1_op_sched
  import nv_nvdla_sdp_x1_op_sched_pkg::*;
(
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic                        op_en,
  input  logic [DIM_W-1:0]            cfg_width,
  input  logic [DIM_W-1:0]            cfg_height,
  input  logic [DIM_W-1:0]            cfg_channel,
  input  logic                        cfg_alu_src,
  input  logic                        cfg_alu_bypass,
  input  logic                        cfg_mul_src,
  input  logic                        cfg_mul_bypass,
  nv_nvdla_sdp_x1_op_sched_if.slave   dp,
  output logic                        busy,
  output logic                        done,
  output logic [31:0]                 perf_stall_cnt
);

  sched_state_e     state, state_nxt;
  logic [DIM_W-1:0] width_r, height_r, channel_r;
  logic             alu_act_r, mul_act_r;
  logic [DIM_W:0]   group_cnt;
  logic             alu_full, mul_full;
  logic [OP_DW-1:0] alu_op, mul_op;
  logic             start, accept, in_prdy, fetch_left, slots_empty, any_act;

  assign start       = op_en & (state == ST_IDLE);
  assign any_act     = alu_act_r | mul_act_r;
  assign fetch_left  = (group_cnt <= {1'b0, channel_r});
  assign slots_empty = ~(alu_act_r & alu_full) & ~(mul_act_r & mul_full);
  assign in_prdy     = (state == ST_RUN) & any_act & fetch_left & slots_empty;
  assign accept      = dp.op_in_pvld & in_prdy;

  // State register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a job with no active channel passes straight through RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (op_en) state_nxt = ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (~any_act | (~fetch_left & slots_empty)) state_nxt = ST_DONE;
        else                                         state_nxt = ST_RUN;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Configuration latch and fetched-group counter; cfg only moves on a start in IDLE.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      width_r   <= '0;
      height_r  <= '0;
      channel_r <= '0;
      alu_act_r <= 1'b0;
      mul_act_r <= 1'b0;
      group_cnt <= '0;
    end else if (start) begin
      width_r   <= cfg_width;
      height_r  <= cfg_height;
      channel_r <= cfg_channel;
      alu_act_r <= chn_active(cfg_alu_src, cfg_alu_bypass);
      mul_act_r <= chn_active(cfg_mul_src, cfg_mul_bypass);
      group_cnt <= '0;
    end else if (accept) begin
      group_cnt <= group_cnt + (DIM_W+1)'(1);
    end
  end

  nv_nvdla_sdp_x1_op_slot u_alu_slot (
    .clk        (nvdla_core_clk),
    .rst        (nvdla_core_rst),
    .load       (accept & alu_act_r),
    .load_data  (dp.op_in_pd[OP_DW-1:0]),
    .cfg_width  (width_r),
    .cfg_height (height_r),
    .op_prdy    (dp.chn_alu_op_prdy),
    .full       (alu_full),
    .op         (alu_op)
  );

  nv_nvdla_sdp_x1_op_slot u_mul_slot (
    .clk        (nvdla_core_clk),
    .rst        (nvdla_core_rst),
    .load       (accept & mul_act_r),
    .load_data  (dp.op_in_pd[PD_W-1:OP_DW]),
    .cfg_width  (width_r),
    .cfg_height (height_r),
    .op_prdy    (dp.chn_mul_op_prdy),
    .full       (mul_full),
    .op         (mul_op)
  );

  // Slot registers keep stale data from earlier jobs, so inactive channels are forced to 0.
  assign dp.op_in_prdy      = in_prdy;
  assign dp.chn_alu_op_pvld = alu_full;
  assign dp.chn_alu_op      = alu_act_r ? alu_op : '0;
  assign dp.chn_mul_op_pvld = mul_full;
  assign dp.chn_mul_op      = mul_act_r ? mul_op : '0;
  assign busy               = (state != ST_IDLE);
  assign done               = (state == ST_DONE);

`ifdef NVDLA_SDP_X1_OP_SCHED_PERF_EN
  logic        stall;
  logic [31:0] stall_cnt;

  assign stall = (state == ST_RUN) & ((alu_act_r & ~alu_full) | (mul_act_r & ~mul_full));

  // Saturating stall counter, cleared when a new job starts.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_cnt <= 32'd0;
    end else if (start) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_x1_op_sched.sv
// Self-checking bench for nv_nvdla_sdp_x1_op_sched: vector table, directed corner
// cases and randomized jobs against a queue-based replay model.
module tb_nv_nvdla_sdp_x1_op_sched;
  import nv_nvdla_sdp_x1_op_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_en;
  logic [12:0] cfg_width, cfg_height, cfg_channel;
  logic        cfg_alu_src, cfg_alu_bypass, cfg_mul_src, cfg_mul_bypass;
  logic        busy, done;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] pd_list[$];
  logic [15:0] obs_alu[$];
  logic [15:0] obs_mul[$];

  typedef struct {
    logic [12:0] w, h, c;
    logic [3:0]  fl;      // {alu_src, alu_bypass, mul_src, mul_bypass}
    int          beats, alu_hs, mul_hs;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  nv_nvdla_sdp_x1_op_sched_if bus ();

  nv_nvdla_sdp_x1_op_sched dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .op_en          (op_en),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .cfg_channel    (cfg_channel),
    .cfg_alu_src    (cfg_alu_src),
    .cfg_alu_bypass (cfg_alu_bypass),
    .cfg_mul_src    (cfg_mul_src),
    .cfg_mul_bypass (cfg_mul_bypass),
    .dp             (bus),
    .busy           (busy),
    .done           (done),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [12:0] w, h, c, input logic [3:0] fl);
    cfg_width = w; cfg_height = h; cfg_channel = c;
    {cfg_alu_src, cfg_alu_bypass, cfg_mul_src, cfg_mul_bypass} = fl;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_in_prdy"}, bus.op_in_prdy, 1'b0);
    chk({tag, "_alu_pvld"}, bus.chn_alu_op_pvld, 1'b0);
    chk({tag, "_mul_pvld"}, bus.chn_mul_op_pvld, 1'b0);
    chk({tag, "_alu_op"}, bus.chn_alu_op, 16'd0);
    chk({tag, "_mul_op"}, bus.chn_mul_op, 16'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_perf"}, perf_stall_cnt, 32'd0);
  endtask

  // Runs one job. The model: every accepted beat queues each active channel's
  // half (w+1)*(h+1) times; the channel outputs must drain those queues in order.
  task automatic run_op(input logic [12:0] w, h, c, input logic [3:0] fl,
                        input int pv_pct, pr_pct, mul_block, input bit poke,
                        output int beats, alu_hs, mul_hs, busy_cyc);
    logic [15:0] aq[$];
    logic [15:0] mq[$];
    bit          alu_act, mul_act, seen_done, exp_prdy;
    int          reps, cyc, stall;
    logic [31:0] pd;
    alu_act = fl[3] & ~fl[2];
    mul_act = fl[1] & ~fl[0];
    reps = (int'(w) + 1) * (int'(h) + 1);
    beats = 0; alu_hs = 0; mul_hs = 0; cyc = 0; stall = 0; seen_done = 1'b0;
    obs_alu.delete(); obs_mul.delete();
    @(posedge clk); #1;
    set_cfg(w, h, c, fl);
    op_en = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    while (!seen_done && cyc < 20000) begin
      bus.op_in_pvld      = ($urandom_range(99) < pv_pct);
      bus.op_in_pd        = (pd_list.size() != 0) ? pd_list[0] : $urandom();
      bus.chn_alu_op_prdy = ($urandom_range(99) < pr_pct);
      bus.chn_mul_op_prdy = (cyc < mul_block) ? 1'b0 : ($urandom_range(99) < pr_pct);
      if (poke && $urandom_range(7) == 0) begin
        set_cfg(13'($urandom()), 13'($urandom()), 13'($urandom()), 4'($urandom()));
        op_en = 1'b1;
      end else begin
        op_en = 1'b0;
      end
      @(negedge clk);
      chk("busy_run", busy, 1'b1);
      exp_prdy = !done && (alu_act || mul_act) && (beats < int'(c) + 1)
                 && aq.size() == 0 && mq.size() == 0;
      chk("op_in_prdy", bus.op_in_prdy, exp_prdy);
      if (!done && ((alu_act && aq.size() == 0) || (mul_act && mq.size() == 0))) stall++;
      chk("alu_pvld", bus.chn_alu_op_pvld, aq.size() != 0);
      chk("mul_pvld", bus.chn_mul_op_pvld, mq.size() != 0);
      if (!alu_act) chk("alu_inactive_data", bus.chn_alu_op, 16'd0);
      if (!mul_act) chk("mul_inactive_data", bus.chn_mul_op, 16'd0);
      if (bus.chn_alu_op_pvld && bus.chn_alu_op_prdy) begin
        if (aq.size() != 0) begin
          chk("alu_op", bus.chn_alu_op, aq[0]);
          void'(aq.pop_front());
        end
        alu_hs++;
        obs_alu.push_back(bus.chn_alu_op);
      end
      if (bus.chn_mul_op_pvld && bus.chn_mul_op_prdy) begin
        if (mq.size() != 0) begin
          chk("mul_op", bus.chn_mul_op, mq[0]);
          void'(mq.pop_front());
        end
        mul_hs++;
        obs_mul.push_back(bus.chn_mul_op);
      end
      if (bus.op_in_pvld && bus.op_in_prdy) begin
        beats++;
        pd = bus.op_in_pd;
        if (alu_act) repeat (reps) aq.push_back(pd[15:0]);
        if (mul_act) repeat (reps) mq.push_back(pd[31:16]);
        if (pd_list.size() != 0) void'(pd_list.pop_front());
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_drained", aq.size() + mq.size(), 0);
      end
      cyc++;
      @(posedge clk); #1;
    end
    op_en = 1'b0;
    bus.op_in_pvld = 1'b0;
    bus.chn_alu_op_prdy = 1'b0;
    bus.chn_mul_op_prdy = 1'b0;
    chk("done_seen", seen_done, 1'b1);
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("done_after", done, 1'b0);
`ifdef NVDLA_SDP_X1_OP_SCHED_PERF_EN
    chk("perf_stall", perf_stall_cnt, stall);
`else
    chk("perf_tied", perf_stall_cnt, 32'd0);
`endif
    busy_cyc = cyc;
  endtask

  initial begin
    int          b, ah, mh, bc;
    logic [12:0] w, h, c;
    logic [3:0]  fl;
    logic [15:0] e_alu[4];
    logic [15:0] e_mul[4];

    tbl[0] = '{w: 13'd0, h: 13'd0, c: 13'd0, fl: 4'b1010, beats: 1, alu_hs: 1,  mul_hs: 1};
    tbl[1] = '{w: 13'd2, h: 13'd1, c: 13'd1, fl: 4'b1010, beats: 2, alu_hs: 12, mul_hs: 12};
    tbl[2] = '{w: 13'd1, h: 13'd2, c: 13'd2, fl: 4'b1000, beats: 3, alu_hs: 18, mul_hs: 0};
    tbl[3] = '{w: 13'd3, h: 13'd0, c: 13'd1, fl: 4'b1110, beats: 2, alu_hs: 0,  mul_hs: 8};
    tbl[4] = '{w: 13'd1, h: 13'd1, c: 13'd3, fl: 4'b0000, beats: 0, alu_hs: 0,  mul_hs: 0};
    tbl[5] = '{w: 13'd0, h: 13'd2, c: 13'd1, fl: 4'b1111, beats: 0, alu_hs: 0,  mul_hs: 0};

    op_en = 1'b0;
    set_cfg(13'd0, 13'd0, 13'd0, 4'b0000);
    bus.op_in_pvld = 1'b0; bus.op_in_pd = 32'd0;
    bus.chn_alu_op_prdy = 1'b0; bus.chn_mul_op_prdy = 1'b0;

    #2;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].w, tbl[i].h, tbl[i].c, tbl[i].fl, 70, 70, 0, 1'b1, b, ah, mh, bc);
      chk($sformatf("tbl%0d_beats", i), b, tbl[i].beats);
      chk($sformatf("tbl%0d_alu_hs", i), ah, tbl[i].alu_hs);
      chk($sformatf("tbl%0d_mul_hs", i), mh, tbl[i].mul_hs);
    end

    // Two groups of width 2 with always-ready consumers.
    pd_list = '{32'h0002_0001, 32'h0004_0003};
    run_op(13'd1, 13'd0, 13'd1, 4'b1010, 100, 100, 0, 1'b0, b, ah, mh, bc);
    e_alu = '{16'd1, 16'd1, 16'd3, 16'd3};
    e_mul = '{16'd2, 16'd2, 16'd4, 16'd4};
    chk("two_grp_alu_cnt", obs_alu.size(), 4);
    chk("two_grp_mul_cnt", obs_mul.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_alu.size()) chk($sformatf("two_grp_alu%0d", i), obs_alu[i], e_alu[i]);
      if (i < obs_mul.size()) chk($sformatf("two_grp_mul%0d", i), obs_mul[i], e_mul[i]);
    end

    // ALU only, single beat.
    pd_list = '{32'hBEEF_1234};
    run_op(13'd0, 13'd0, 13'd0, 4'b1011, 100, 100, 0, 1'b0, b, ah, mh, bc);
    chk("alu_only_beats", b, 1);
    chk("alu_only_cnt", obs_alu.size(), 1);
    if (obs_alu.size() != 0) chk("alu_only_val", obs_alu[0], 16'h1234);
    chk("alu_only_mul_hs", mh, 0);
    pd_list.delete();

    // MUL consumer stalled for 10 cycles.
    run_op(13'd1, 13'd0, 13'd1, 4'b1010, 100, 100, 10, 1'b0, b, ah, mh, bc);
    chk("mul_stall_beats", b, 2);
`ifdef NVDLA_SDP_X1_OP_SCHED_PERF_EN
    chk("mul_stall_perf_ge10", perf_stall_cnt >= 32'd10, 1'b1);
`endif

    // No active channel: RUN then DONE, no beats.
    run_op(13'd5, 13'd5, 13'd5, 4'b0101, 100, 100, 0, 1'b0, b, ah, mh, bc);
    chk("none_busy_cycles", bc, 2);
    chk("none_beats", b, 0);

    // Reset while slots hold operands.
    @(posedge clk); #1;
    set_cfg(13'd3, 13'd0, 13'd2, 4'b1010);
    op_en = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    bus.op_in_pvld = 1'b1;
    bus.op_in_pd = 32'hA5A5_5A5A;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_alu_full", bus.chn_alu_op_pvld, 1'b1);
    chk("pre_reset_mul_full", bus.chn_mul_op_pvld, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_quiet("mid_reset");
    @(negedge clk);
    bus.op_in_pvld = 1'b0;
    rst = 1'b0;
    run_op(13'd0, 13'd1, 13'd2, 4'b1010, 100, 100, 0, 1'b0, b, ah, mh, bc);
    chk("post_reset_beats", b, 3);
    chk("post_reset_alu_hs", ah, 6);

    // Maximum width: one operand replayed 8192 times.
    run_op(13'd8191, 13'd0, 13'd0, 4'b1000, 100, 100, 0, 1'b0, b, ah, mh, bc);
    chk("wmax_beats", b, 1);
    chk("wmax_alu_hs", ah, 8192);

    // Randomized jobs.
    for (int i = 0; i < 20; i++) begin
      w  = 13'($urandom_range(3));
      h  = 13'($urandom_range(3));
      c  = 13'($urandom_range(3));
      fl = 4'($urandom());
      run_op(w, h, c, fl, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
             0, 1'b1, b, ah, mh, bc);
      chk($sformatf("rnd%0d_beats", i), b,
          ((fl[3] & ~fl[2]) | (fl[1] & ~fl[0])) ? int'(c) + 1 : 0);
      chk($sformatf("rnd%0d_alu_hs", i), ah,
          (fl[3] & ~fl[2]) ? (int'(c) + 1) * (int'(w) + 1) * (int'(h) + 1) : 0);
      chk($sformatf("rnd%0d_mul_hs", i), mh,
          (fl[1] & ~fl[0]) ? (int'(c) + 1) * (int'(w) + 1) * (int'(h) + 1) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
